mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_pkg.sv | 37 +++
 rtl/mult_arbiter_if.sv | 31 +++
 rtl/mult_arbiter_mult.sv | 47 ++++
 rtl/mult_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
//   MULT_LAT_DEFAULT : default multiplier latency, in cycles from issue to done
//   NUM_REQ          : number of requesters (fixed at 2)
//   DATA_W           : operand and product width
//   req_id_e         : requester index
//   tag_t            : {valid, id} carried alongside each in-flight operation
//   arb_grant()      : round-robin grant for two requesters
package mult_arbiter_pkg;

  localparam int unsigned MULT_LAT_DEFAULT = 8;
  localparam int unsigned NUM_REQ          = 2;
  localparam int unsigned DATA_W           = 64;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  // Under contention the requester that was not granted last (lp) wins.
  function automatic logic [NUM_REQ-1:0] arb_grant(input logic [NUM_REQ-1:0] req,
                                                   input req_id_e             lp);
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (req == 2'b11) begin
      g = (lp == REQ1) ? 2'b01 : 2'b10;
    end else begin
      g = req;
    end
    return g;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bus of the multiplier arbiter.
//   req, operands   : requester -> arbiter (held until granted)
//   gnt             : combinational one-hot-or-zero grant
//   rsp_valid       : one-cycle completion pulse routed to the issuer
//   product         : result, qualified by rsp_valid
//   err             : sticky tag/done inconsistency flag
// master = requester side, slave = arbiter side.
interface mult_arbiter_if;
  import mult_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [DATA_W-1:0]  mcand0;
  logic [DATA_W-1:0]  mplier0;
  logic [DATA_W-1:0]  mcand1;
  logic [DATA_W-1:0]  mplier1;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0]  product;
  logic               err;

  modport master (
    output req, mcand0, mplier0, mcand1, mplier1,
    input  gnt, rsp_valid, product, err
  );

  modport slave (
    input  req, mcand0, mplier0, mcand1, mplier1,
    output gnt, rsp_valid, product, err
  );

endinterface

// File: rtl/mult_arbiter_mult.sv
// Fixed-latency pipelined multiplier (low DATA_W bits of the product).
//   clk, rst        : clock, asynchronous active-high reset
//   start           : accept mcand/mplier this cycle
//   mcand, mplier   : operands
//   done            : result of the operation accepted LAT cycles earlier
//   product         : result, qualified by done
// The multiply sits ahead of a LAT-deep register chain so synthesis can
// retime the partial products across the stages.
module mult_arbiter_mult
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned LAT = MULT_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mplier,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic [LAT-1:0]    vld;
  logic [DATA_W-1:0] stage [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      vld[0] <= start;
      if (start) begin
        stage[0] <= mcand * mplier;
      end
      for (int unsigned i = 1; i < LAT; i++) begin
        vld[i]   <= vld[i-1];
        stage[i] <= stage[i-1];
      end
    end
  end

  assign done    = vld[LAT-1];
  assign product = stage[LAT-1];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between two requesters.
//   clock, reset : clock, asynchronous active-high reset
//   bus          : requester bus (slave side), see mult_arbiter_if
// At most one request is granted and issued per cycle; a tag pipe matching the
// multiplier latency records who issued each operation so the result can be
// routed back. A done without a matching tag (or vice versa) sets err.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  mult_arbiter_if.slave bus
);

  req_id_e           lp;
  logic [NUM_REQ-1:0] gnt;
  logic              start;
  req_id_e           gnt_id;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  tag_t              tag_pipe [MULT_LAT];
  tag_t              tail;
  logic              mult_done;
  logic [DATA_W-1:0] mult_product;
  logic              rsp_ok;
  logic              mismatch;
  logic              err_q;

  // Grant is combinational and forced low while reset is held.
  always_comb begin
    gnt    = reset ? '0 : arb_grant(bus.req, lp);
    start  = |gnt;
    gnt_id = gnt[1] ? REQ1 : REQ0;
    op_a   = gnt[1] ? bus.mcand1  : bus.mcand0;
    op_b   = gnt[1] ? bus.mplier1 : bus.mplier0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lp    <= REQ1;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < MULT_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      if (start) begin
        lp <= gnt_id;
      end
      err_q       <= err_q | mismatch;
      tag_pipe[0] <= '{valid: start, id: gnt_id};
      for (int unsigned i = 1; i < MULT_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  mult_arbiter_mult #(
    .LAT (MULT_LAT)
  ) u_mult (
    .clk     (clock),
    .rst     (reset),
    .start   (start),
    .mcand   (op_a),
    .mplier  (op_b),
    .done    (mult_done),
    .product (mult_product)
  );

  always_comb begin
    tail          = tag_pipe[MULT_LAT-1];
    rsp_ok        = mult_done & tail.valid;
    mismatch      = mult_done ^ tail.valid;
    bus.gnt       = gnt;
    bus.rsp_valid = '0;
    if (rsp_ok) begin
      bus.rsp_valid = (tail.id == REQ1) ? 2'b10 : 2'b01;
    end
    bus.product   = rsp_ok ? mult_product : '0;
    bus.err       = err_q;
  end

endmodule
